// File: rtl/add_accum_if.sv
// Valid/ready handshake bundle for the add_accum stage: sample input and result output.
interface add_accum_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic signed [WIDTH-1:0]     in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/add_accum.sv
// Sums COUNT signed samples and holds the total on a valid/ready port until drained.
// ADD_ACCUM_SAT_EN selects saturating adds (sticky per result); default build wraps.
module add_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4
) (
  input  logic       clock,
  input  logic       reset,
  add_accum_if.slave bus,
  output logic [7:0] count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        accept;

  assign sample_ext = ACC_WIDTH'(bus.in_data);
  assign accept     = (state == ACCUM) && bus.in_ready && bus.in_valid;

`ifdef ADD_ACCUM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide;
  logic                      clamped;
  logic                      clamp_now;

  // One guard bit exposes overflow; once clamped, the result is frozen until completion.
  always_comb begin
    wide      = {acc[ACC_WIDTH-1], acc} + {sample_ext[ACC_WIDTH-1], sample_ext};
    clamp_now = 1'b0;
    sum       = wide[ACC_WIDTH-1:0];
    if (clamped) begin
      sum = acc;
    end else if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      sum       = wide[ACC_WIDTH] ? SMIN : SMAX;
      clamp_now = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clamped <= 1'b0;
    end else if (accept) begin
      clamped <= (count == LAST) ? 1'b0 : (clamped | clamp_now);
    end
  end
`else
  assign sum = acc + sample_ext;
`endif

  // in_ready stays low for one ACCUM cycle after a drain, giving the single bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ACCUM;
      acc           <= '0;
      count         <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (!bus.in_ready) begin
            bus.in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            if (count == LAST) begin
              bus.out_data  <= sum;
              bus.out_valid <= 1'b1;
              bus.in_ready  <= 1'b0;
              acc           <= '0;
              count         <= '0;
              state         <= HOLD;
            end else begin
              acc   <= sum;
              count <= count + 8'd1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_add_accum.sv
// Scoreboard bench for add_accum: main COUNT=4 instance plus 8-bit and COUNT=1 variants.
module tb_add_accum;

  logic clock;
  logic reset;
  logic [7:0] cnt0, cnt8, cnt1;

  add_accum_if #(.WIDTH(8), .ACC_WIDTH(16)) i0 ();
  add_accum_if #(.WIDTH(8), .ACC_WIDTH(8))  i8 ();
  add_accum_if #(.WIDTH(8), .ACC_WIDTH(16)) i1 ();

  add_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) u_dut (
    .clock(clock), .reset(reset), .bus(i0), .count(cnt0));
  add_accum #(.WIDTH(8), .ACC_WIDTH(8), .COUNT(4)) u_dut8 (
    .clock(clock), .reset(reset), .bus(i8), .count(cnt8));
  add_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(i1), .count(cnt1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  logic signed [15:0] exp_q[$];
  int unsigned        pop_cyc[$];
  logic signed [15:0] m_acc = '0;
  int unsigned        m_cnt = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Results are popped on the cycle the handshake completes.
  always @(negedge clock) begin
    if (reset && i0.out_valid && i0.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", longint'(i0.out_data), 0);
      end else begin
        check("sb_result", longint'(i0.out_data), longint'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input int unsigned sel, input int s);
    logic ok;
    int unsigned t;
    ok = 1'b0;
    t  = 0;
    case (sel)
      0: begin i0.in_data = 8'(s); i0.in_valid = 1'b1; end
      1: begin i8.in_data = 8'(s); i8.in_valid = 1'b1; end
      default: begin i1.in_data = 8'(s); i1.in_valid = 1'b1; end
    endcase
    while (!ok && t < 50) begin
      @(negedge clock);
      case (sel)
        0: ok = i0.in_ready;
        1: ok = i8.in_ready;
        default: ok = i1.in_ready;
      endcase
      @(posedge clock);
      #1;
      t++;
    end
    i0.in_valid = 1'b0;
    i8.in_valid = 1'b0;
    i1.in_valid = 1'b0;
    if (!ok) begin
      check("send_timeout", 0, 1);
    end else if (sel == 0) begin
      m_acc = m_acc + 16'(s);
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(m_acc);
        m_acc = '0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    check("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  initial begin
    reset = 1'b0;
    i0.in_valid = 1'b0; i0.in_data = '0; i0.out_ready = 1'b0;
    i8.in_valid = 1'b0; i8.in_data = '0; i8.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.in_data = '0; i1.out_ready = 1'b0;

    // reset
    repeat (3) @(negedge clock);
    check("rst_out_valid", longint'(i0.out_valid), 0);
    check("rst_out_data", longint'(i0.out_data), 0);
    check("rst_count", longint'(cnt0), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready", longint'(i0.in_ready), 1);

    // steady stream: 8 samples of 15, two results of 60 six cycles apart
    @(posedge clock); #1;
    i0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, 15);
      if (i == 1) begin
        @(negedge clock);
        check("steady_count2", longint'(cnt0), 2);
        @(posedge clock); #1;
      end
      if (i == 3) check("steady_latency", longint'(i0.out_valid), 1);
    end
    wait_idle();
    if (pop_cyc.size() >= 2)
      check("steady_period", longint'(pop_cyc[1] - pop_cyc[0]), 6);
    else
      check("steady_pops", longint'(pop_cyc.size()), 2);

    // backpressure
    i0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 15);
    repeat (3) @(negedge clock);
    check("bp_out_valid", longint'(i0.out_valid), 1);
    check("bp_out_data", longint'(i0.out_data), 60);
    check("bp_in_ready", longint'(i0.in_ready), 0);
    check("bp_count", longint'(cnt0), 0);
    @(negedge clock);
    check("bp_stable", longint'(i0.out_data), 60);
    @(posedge clock); #1;
    i0.out_ready = 1'b1;
    wait_idle();
    check("bp_drained", longint'(i0.out_valid), 0);

    // signed samples, expected -5
    send(0, -3); send(0, -128); send(0, 127); send(0, -1);
    check("signed_value", longint'(exp_q[0]), -5);
    wait_idle();

    // overflow on the 8-bit accumulator
    send(1, 127); send(1, 127); send(1, 0); send(1, 0);
    @(negedge clock);
    check("ovf_valid", longint'(i8.out_valid), 1);
`ifdef ADD_ACCUM_SAT_EN
    check("ovf_data", longint'(i8.out_data), 127);
`else
    check("ovf_data", longint'(i8.out_data), -2);
`endif
    @(posedge clock); #1;
    i8.out_ready = 1'b1;
    @(posedge clock); #1;
    check("ovf_drained", longint'(i8.out_valid), 0);

    // COUNT==1: each sample is a result
    send(2, 5);
    @(negedge clock);
    check("c1_valid", longint'(i1.out_valid), 1);
    check("c1_data", longint'(i1.out_data), 5);
    check("c1_in_ready", longint'(i1.in_ready), 0);
    check("c1_count", longint'(cnt1), 0);
    @(posedge clock); #1;
    i1.out_ready = 1'b1;
    send(2, -7);
    @(negedge clock);
    check("c1_data2", longint'(i1.out_data), -7);

    // reset mid-result discards the partial sum
    @(posedge clock); #1;
    send(0, 15); send(0, 15);
    @(negedge clock);
    check("mid_count2", longint'(cnt0), 2);
    @(posedge clock); #1;
    reset = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    @(negedge clock);
    check("mid_rst_count", longint'(cnt0), 0);
    check("mid_rst_valid", longint'(i0.out_valid), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 15);
    check("mid_expect", longint'(exp_q[0]), 60);
    wait_idle();
    check("sb_results", longint'(pop_cyc.size()), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
